// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the single SSRAM controller port.
//
// The framebuffer has priority. A CPU request is guaranteed service after at
// most FB_MAX consecutive framebuffer transfers. A request that is issued and
// stalled keeps its grant until the controller accepts it, so held
// Avalon-style requests never change owner mid-transfer.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   cpu_*                 CPU master: id, address, read/write, data, byte mask,
//                         waitrequest out
//   fb_*                  framebuffer read master: address, read,
//                         waitrequest out, readdatavalid out
//   mem_*                 controller side: id, address, read/write, data,
//                         byte mask out; waitrequest, readdataid in
module mem_arbiter #(
   parameter logic [1:0]  ID_FB  = 2'd3,
   parameter int unsigned FB_MAX = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic        clock,
   input  logic        reset,

   input  logic [1:0]  cpu_id,
   input  logic [29:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_writedata,
   input  logic [3:0]  cpu_writedatamask,
   output logic        cpu_waitrequest,

   input  logic [29:0] fb_address,
   input  logic        fb_read,
   output logic        fb_waitrequest,
   output logic        fb_readdatavalid,

   output logic [1:0]  mem_id,
   output logic [29:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_writedatamask,
   input  logic        mem_waitrequest,
   input  logic [1:0]  mem_readdataid
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_FB   = 2'd2
   } owner_t;

   localparam logic [CNT_W-1:0] FB_MAX_C = CNT_W'(FB_MAX);

   owner_t           owner;
   owner_t           sel;
   logic             lock;
   logic [CNT_W-1:0] streak;

   logic cpu_req;
   logic fb_req;
   logic accept;

   assign cpu_req = cpu_read | cpu_write;
   assign fb_req  = fb_read;
   assign accept  = (sel != OWN_NONE) && !mem_waitrequest;

   // Same-cycle selection; a stalled transfer keeps its owner.
   always_comb begin
      sel = OWN_NONE;
      if (lock)
         sel = owner;
      else if (fb_req && (!cpu_req || (streak < FB_MAX_C)))
         sel = OWN_FB;
      else if (cpu_req)
         sel = OWN_CPU;
   end

   // Output mux. The fb read strobe follows fb_read rather than a constant 1
   // so that a request withdrawn under lock presents an idle bus.
   always_comb begin
      mem_id            = '0;
      mem_address       = '0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      mem_writedata     = cpu_writedata;
      mem_writedatamask = cpu_writedatamask;
      cpu_waitrequest   = 1'b1;
      fb_waitrequest    = 1'b1;
      case (sel)
         OWN_FB: begin
            mem_id         = ID_FB;
            mem_address    = fb_address;
            mem_read       = fb_read;
            fb_waitrequest = mem_waitrequest;
         end
         OWN_CPU: begin
            mem_id          = cpu_id;
            mem_address     = cpu_address;
            mem_read        = cpu_read;
            mem_write       = cpu_write;
            cpu_waitrequest = mem_waitrequest;
         end
         default: ;
      endcase
      if (reset) begin
         mem_id            = '0;
         mem_address       = '0;
         mem_read          = 1'b0;
         mem_write         = 1'b0;
         mem_writedata     = '0;
         mem_writedatamask = '0;
         cpu_waitrequest   = 1'b1;
         fb_waitrequest    = 1'b1;
      end
   end

   // Read data routing is purely by id, independent of the current grant.
   assign fb_readdatavalid = (mem_readdataid == ID_FB);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner  <= OWN_NONE;
         lock   <= 1'b0;
         streak <= '0;
      end else begin
         owner <= sel;
         lock  <= (sel != OWN_NONE) && mem_waitrequest;
         if (!cpu_req)
            streak <= '0;
         else if (accept && (sel == OWN_CPU))
            streak <= '0;
         else if (accept && (sel == OWN_FB) && (streak != '1))
            streak <= streak + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int FB_MAX = 8;
  localparam int CNT_W  = 8;
  localparam int RUN_SAT = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cpu_id = '0;
  logic [29:0] cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_writedatamask = '0;
  logic        cpu_waitrequest;
  logic [29:0] fb_address = '0;
  logic        fb_read = 1'b0;
  logic        fb_waitrequest;
  logic        fb_readdatavalid;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic        mem_waitrequest = 1'b0;
  logic [1:0]  mem_readdataid = '0;

  mem_arbiter #(.ID_FB(2'd3), .FB_MAX(FB_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_id(cpu_id), .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_writedatamask(cpu_writedatamask), .cpu_waitrequest(cpu_waitrequest),
    .fb_address(fb_address), .fb_read(fb_read),
    .fb_waitrequest(fb_waitrequest), .fb_readdatavalid(fb_readdatavalid),
    .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_waitrequest(mem_waitrequest),
    .mem_readdataid(mem_readdataid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  id;
    logic [29:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic        cpu_wait;
    logic        fb_wait;
    logic        fb_rdv;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   done = 1'b0;

  int   m_hold = 0;
  int   m_run = 0;
  int   p_who = 0;
  logic p_wait = 1'b0;
  logic p_cpureq = 1'b0;
  logic p_rst = 1'b1;

  task automatic cycle(input logic rst_lvl, input logic pulse,
                       input logic c_rd, input logic c_wr, input logic [29:0] c_addr,
                       input logic f_rd, input logic [29:0] f_addr,
                       input logic w, input logic [1:0] rid);
    int   who;
    obs_t e;
    @(posedge clock);
    if (p_rst) begin
      m_hold = 0;
      m_run  = 0;
    end else begin
      m_hold = (p_who != 0 && p_wait) ? p_who : 0;
      if (!p_cpureq)                  m_run = 0;
      else if (p_who == 1 && !p_wait) m_run = 0;
      else if (p_who == 2 && !p_wait && m_run < RUN_SAT) m_run = m_run + 1;
    end
    #1;
    cpu_read          = c_rd;
    cpu_write         = c_wr;
    cpu_address       = c_addr;
    cpu_id            = 2'($urandom_range(0, 2));
    cpu_writedata     = $urandom;
    cpu_writedatamask = 4'($urandom);
    fb_read           = f_rd;
    fb_address        = f_addr;
    mem_waitrequest   = w;
    mem_readdataid    = rid;
    reset             = rst_lvl | pulse;
    if (pulse) begin
      m_hold = 0;
      m_run  = 0;
      #2 reset = rst_lvl;
    end
    if (rst_lvl) begin
      m_hold = 0;
      m_run  = 0;
    end
    if (rst_lvl)                                          who = 0;
    else if (m_hold != 0)                                 who = m_hold;
    else if (f_rd && (!(c_rd | c_wr) || m_run < FB_MAX)) who = 2;
    else if (c_rd | c_wr)                                 who = 1;
    else                                                  who = 0;
    e = '0;
    e.cpu_wait = 1'b1;
    e.fb_wait  = 1'b1;
    e.wd       = rst_lvl ? 32'd0 : cpu_writedata;
    e.mask     = rst_lvl ? 4'd0 : cpu_writedatamask;
    e.fb_rdv   = (rid == 2'd3);
    if (who == 2) begin
      e.rd = f_rd; e.id = 2'd3; e.addr = f_addr; e.fb_wait = w;
    end else if (who == 1) begin
      e.rd = c_rd; e.wr = c_wr; e.id = cpu_id; e.addr = c_addr; e.cpu_wait = w;
    end
    exp_q.push_back(e);
    p_who = who;
    p_wait = w;
    p_cpureq = c_rd | c_wr;
    p_rst = rst_lvl;
  endtask

  task automatic check_idle(input string tag);
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 ||
        cpu_waitrequest !== 1'b1 || fb_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL %s: got rd=%b wr=%b cw=%b fw=%b expected rd=0 wr=0 cw=1 fw=1",
               tag, mem_read, mem_write, cpu_waitrequest, fb_waitrequest);
    end
  endtask

  initial begin
    obs_t a, e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{mem_read, mem_write, mem_id, mem_address, mem_writedata,
              mem_writedatamask, cpu_waitrequest, fb_waitrequest, fb_readdatavalid};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h expected %h (rd wr id addr wd mask cw fw rdv)",
                   cyc, a, e);
        end
        checks++;
        if (fb_readdatavalid !== (mem_readdataid == 2'd3)) begin
          errors++;
          $display("FAIL readdatavalid cycle %0d: got %b with readdataid %0d",
                   cyc, fb_readdatavalid, mem_readdataid);
        end
        cyc++;
      end
      if (done && exp_q.size() == 0) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 3; i++) cycle(1, 0, 1, 1, 30'h55, 1, 30'h66, 0, 2'd3);
    for (int unsigned i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    check_idle("idle after reset");
    cycle(0, 0, 1, 0, 30'h100, 0, 30'h200, 1, 2'd0);
    cycle(0, 0, 1, 0, 30'h100, 1, 30'h200, 1, 2'd0);
    cycle(0, 0, 1, 0, 30'h100, 1, 30'h200, 1, 2'd0);
    cycle(0, 0, 1, 0, 30'h100, 1, 30'h200, 0, 2'd0);
    cycle(0, 0, 0, 0, 30'h100, 1, 30'h200, 0, 2'd3);
    for (int unsigned i = 0; i < 40; i++) cycle(0, 0, 0, 1, 30'h3C0 + 30'(i), 1, 30'h1000 + 30'(i), 0, 2'(i));
    for (int unsigned i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 1, 30'h2000 + 30'(i), 0, 2'd3);
    for (int unsigned i = 0; i < 12; i++) cycle(0, 0, 1, 0, 30'h77, 1, 30'h2100 + 30'(i), 0, 2'd1);
    cycle(0, 0, 0, 0, 0, 1, 30'h3000, 1, 2'd0);
    cycle(0, 0, 0, 0, 0, 1, 30'h3000, 1, 2'd0);
    cycle(1, 0, 0, 0, 0, 1, 30'h3000, 1, 2'd0);
    check_idle("reset during locked fb stall");
    cycle(0, 0, 1, 0, 30'h44, 0, 0, 0, 2'd0);
    cycle(0, 0, 0, 0, 0, 1, 30'h3100, 1, 2'd0);
    cycle(0, 0, 0, 0, 0, 1, 30'h3100, 1, 2'd0);
    cycle(0, 1, 1, 0, 30'h45, 0, 0, 1, 2'd0);
    cycle(0, 0, 1, 0, 30'h45, 0, 0, 0, 2'd0);
    for (int unsigned i = 0; i < 400; i++) begin
      cycle(0, 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 30'($urandom),
            $urandom_range(0, 4) != 0, 30'($urandom),
            $urandom_range(0, 2) == 0, 2'($urandom));
    end
    @(posedge clock);
    done = 1'b1;
  end

endmodule
